// File: rtl/fifo_fallthrough_stage.sv
// Output stage for a registered-read FIFO: issues rd_en on a credit basis and lands words in a
// head/skid pair so the consumer sees a first-word-fall-through valid/ready stream at 1 word/clk.
module fifo_fallthrough_stage #(
  parameter int WIDTH = 72
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_fifo_dout,
  input  logic             i_fifo_empty,
  output logic             o_fifo_rd_en,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_vld,
  input  logic             i_out_rdy,
  output logic [1:0]       o_occupancy
);

  logic             r_pend;
  logic             r_out_vld;
  logic             r_skid_vld;
  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] r_skid_data;

  logic             w_pop;
  logic [1:0]       w_occ;
  logic [2:0]       w_credit;
  logic             w_rd_en;
  logic             w_out_vld_next;
  logic             w_skid_vld_next;
  logic [WIDTH-1:0] w_out_data_next;
  logic [WIDTH-1:0] w_skid_data_next;

  assign w_pop = r_out_vld & i_out_rdy;
  assign w_occ = {1'b0, r_out_vld} + {1'b0, r_skid_vld};

  // Counting the in-flight word reserves a slot for it even if the consumer stalls.
  assign w_credit = {1'b0, w_occ} + {2'b00, r_pend} - {2'b00, w_pop};
  assign w_rd_en  = ~rst & ~i_fifo_empty & (w_credit <= 3'd1);

  always_comb begin
    w_out_vld_next   = r_out_vld;
    w_out_data_next  = r_out_data;
    w_skid_vld_next  = r_skid_vld;
    w_skid_data_next = r_skid_data;
    if (w_pop && r_skid_vld) begin
      w_out_vld_next  = 1'b1;
      w_out_data_next = r_skid_data;
      if (r_pend) begin
        w_skid_data_next = i_fifo_dout;
      end else begin
        w_skid_vld_next = 1'b0;
      end
    end else if (w_pop) begin
      w_out_vld_next = r_pend;
      if (r_pend) begin
        w_out_data_next = i_fifo_dout;
      end
    end else if (r_pend) begin
      if (!r_out_vld) begin
        w_out_vld_next  = 1'b1;
        w_out_data_next = i_fifo_dout;
      end else begin
        w_skid_vld_next  = 1'b1;
        w_skid_data_next = i_fifo_dout;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend      <= 1'b0;
      r_out_vld   <= 1'b0;
      r_skid_vld  <= 1'b0;
      r_out_data  <= '0;
      r_skid_data <= '0;
    end else begin
      r_pend      <= w_rd_en;
      r_out_vld   <= w_out_vld_next;
      r_skid_vld  <= w_skid_vld_next;
      r_out_data  <= w_out_data_next;
      r_skid_data <= w_skid_data_next;
    end
  end

  // Simulation-only sanity checks; synthesis ignores immediate assertions.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(r_pend && (w_occ == 2'd2) && !w_pop))
        else $error("fifo_fallthrough_stage: word landed with occupancy 2 and no pop");
      assert (!(w_rd_en && i_fifo_empty))
        else $error("fifo_fallthrough_stage: fifo_rd_en asserted while fifo_empty");
    end
  end

  assign o_fifo_rd_en = w_rd_en;
  assign o_out_data   = r_out_data;
  assign o_out_vld    = r_out_vld;
  assign o_occupancy  = w_occ;

endmodule

// File: tb/tb_fifo_fallthrough_stage.sv
// Bench: behavioural upstream FIFO, stage treated as an order-preserving pass-through,
// scoreboard of words read from the FIFO checked by a negedge monitor.
module tb_fifo_fallthrough_stage;
  localparam int WIDTH = 72;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] fifo_dout = '0;
  logic             fifo_empty = 1'b1;
  logic             rd_en;
  logic [WIDTH-1:0] out_data;
  logic             out_vld;
  logic             out_rdy = 1'b0;
  logic [1:0]       occ;

  logic             push_en = 1'b0;
  logic [WIDTH-1:0] push_data = '0;

  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] sb[$];
  logic             read_last = 1'b0;
  int               n_checks = 0;
  int               n_pass = 0;
  int               rd_pulses = 0;
  int               delivered = 0;
  int               exp_occ;
  logic             hold_prev = 1'b0;
  logic [WIDTH-1:0] held = '0;
  logic [WIDTH-1:0] exp_word;
  bit               push_done;

  always #5 clk = ~clk;

  fifo_fallthrough_stage #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_fifo_dout (fifo_dout),
    .i_fifo_empty(fifo_empty),
    .o_fifo_rd_en(rd_en),
    .o_out_data  (out_data),
    .o_out_vld   (out_vld),
    .i_out_rdy   (out_rdy),
    .o_occupancy (occ)
  );

  task automatic chk(input bit ok, input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Upstream registered-read FIFO with synchronous reset.
  always @(posedge clk) begin
    logic [WIDTH-1:0] w;
    if (rst) begin
      fifo_q.delete();
      sb.delete();
      fifo_empty <= 1'b1;
      read_last  <= 1'b0;
    end else begin
      if (rd_en && fifo_q.size() != 0) begin
        w = fifo_q.pop_front();
        fifo_dout <= w;
        sb.push_back(w);
        rd_pulses++;
      end
      read_last <= rd_en;
      if (push_en) fifo_q.push_back(push_data);
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Monitor: words in the stage = words read from the FIFO, minus the one still in flight.
  always @(negedge clk) begin
    if (rst) begin
      chk(rd_en == 1'b0, "rd_en_in_reset", WIDTH'(rd_en), '0);
      chk(out_vld == 1'b0, "out_vld_in_reset", WIDTH'(out_vld), '0);
      chk(occ == 2'd0, "occ_in_reset", WIDTH'(occ), '0);
      hold_prev = 1'b0;
    end else begin
      exp_occ = sb.size() - (read_last ? 1 : 0);
      chk(int'(occ) == exp_occ, "occupancy", WIDTH'(occ), WIDTH'(exp_occ));
      chk(out_vld == (exp_occ != 0), "out_vld", WIDTH'(out_vld), WIDTH'(exp_occ != 0));
      if (rd_en) chk(fifo_empty == 1'b0, "rd_en_while_empty", WIDTH'(fifo_empty), '0);
      if (hold_prev) chk(out_data == held, "hold_stable", out_data, held);
      if (out_vld && out_rdy) begin
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected_word", out_data, '0);
        end else begin
          exp_word = sb.pop_front();
          chk(out_data == exp_word, "data_order", out_data, exp_word);
          delivered++;
        end
      end
      hold_prev = out_vld && !out_rdy;
      held      = out_data;
    end
  end

  task automatic push_word(input logic [WIDTH-1:0] v);
    push_en   = 1'b1;
    push_data = v;
    @(posedge clk);
    #1;
    push_en = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((fifo_q.size() != 0 || sb.size() != 0) && t < 600) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk(t < 600, "drain_timeout", WIDTH'(t), WIDTH'(600));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int d0;
    int t;
    repeat (3) @(posedge clk);
    #1;
    chk(out_data == '0, "reset_out_data", out_data, '0);
    rst = 1'b0;

    // 1: single word, latency and a single rd_en pulse
    out_rdy = 1'b1;
    r0 = rd_pulses;
    push_word(72'hA5);
    chk(fifo_empty == 1'b0, "t1_fifo_nonempty", WIDTH'(fifo_empty), '0);
    @(posedge clk); #1;
    chk(out_vld == 1'b0, "t1_vld_early", WIDTH'(out_vld), '0);
    @(posedge clk); #1;
    chk(out_vld == 1'b1, "t1_vld", WIDTH'(out_vld), 1);
    chk(out_data == 72'hA5, "t1_data", out_data, 72'hA5);
    @(posedge clk); #1;
    chk(out_vld == 1'b0, "t1_vld_fall", WIDTH'(out_vld), '0);
    chk(rd_pulses - r0 == 1, "t1_rd_pulses", WIDTH'(rd_pulses - r0), 1);

    // 2: back-to-back burst, no bubble
    fork
      begin
        for (int i = 1; i <= 16; i++) push_word(WIDTH'(i));
      end
      begin
        t = 0;
        while (!out_vld && t < 20) begin
          @(posedge clk); #1;
          t++;
        end
        for (int k = 1; k <= 16; k++) begin
          chk(out_vld == 1'b1, "t2_stream_vld", WIDTH'(out_vld), 1);
          chk(out_data == WIDTH'(k), "t2_data", out_data, WIDTH'(k));
          @(posedge clk); #1;
        end
      end
    join
    wait_drain();

    // 3: stall mid-burst
    d0 = delivered;
    fork
      begin
        for (int i = 1; i <= 12; i++) push_word(WIDTH'(32'h300 + i));
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        out_rdy = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk(occ == 2'd2, "t3_occ_full", WIDTH'(occ), 2);
        chk(rd_en == 1'b0, "t3_rd_en_stalled", WIDTH'(rd_en), '0);
        out_rdy = 1'b1;
      end
    join
    wait_drain();
    chk(delivered - d0 == 12, "t3_count", WIDTH'(delivered - d0), 12);

    // 4: random traffic and random backpressure
    d0 = delivered;
    push_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 200; n++) begin
          while ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          push_word({$urandom, $urandom, 8'($urandom)});
        end
        push_done = 1'b1;
      end
      begin
        while (!push_done) begin
          out_rdy = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        out_rdy = 1'b1;
      end
    join
    wait_drain();
    chk(delivered - d0 == 200, "t4_count", WIDTH'(delivered - d0), 200);

    // 5: asynchronous reset with the stage full
    out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) push_word(WIDTH'(32'h500 + i));
    t = 0;
    while (occ != 2'd2 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk(occ == 2'd2, "t5_occ_before_reset", WIDTH'(occ), 2);
    #2;
    rst = 1'b1;
    #1;
    chk(out_vld == 1'b0, "t5_async_vld", WIDTH'(out_vld), '0);
    chk(occ == 2'd0, "t5_async_occ", WIDTH'(occ), '0);
    chk(rd_en == 1'b0, "t5_async_rd_en", WIDTH'(rd_en), '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_rdy = 1'b1;
    d0 = delivered;
    push_word(WIDTH'(7));
    push_word(WIDTH'(8));
    wait_drain();
    chk(delivered - d0 == 2, "t5_refill_count", WIDTH'(delivered - d0), 2);

    // 6: single word with out_rdy toggling
    d0 = delivered;
    r0 = rd_pulses;
    push_word(WIDTH'(32'h66));
    for (int c = 0; c < 12; c++) begin
      out_rdy = ~out_rdy;
      @(posedge clk); #1;
    end
    out_rdy = 1'b1;
    wait_drain();
    chk(delivered - d0 == 1, "t6_count", WIDTH'(delivered - d0), 1);
    chk(rd_pulses - r0 == 1, "t6_rd_pulses", WIDTH'(rd_pulses - r0), 1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
